// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular buffer of {inst, pc4} pairs.
// Latency: a pushed entry is visible at the head one cycle after the push edge (no fall-through).
// Backpressure: in_ready = !full (no full-bypass on same-cycle pop); out_valid = !empty; flush empties the queue.
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_inst,
    input  logic [WIDTH-1:0]         in_pc4,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_inst,
    output logic [WIDTH-1:0]         out_pc4,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_inst_mem [DEPTH];
    logic [WIDTH-1:0] r_pc4_mem  [DEPTH];

    logic w_push;
    logic w_pop;

    // Status flags come straight from the registered occupancy.
    assign full      = (r_count == CNT_FULL);
    assign empty     = (r_count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = r_count;

    // Flush blocks both sides; a full queue refuses pushes even while popping.
    assign w_push = in_valid && !full  && !flush;
    assign w_pop  = out_ready && !empty && !flush;

    // Head is driven as zero (NOP) whenever nothing is queued.
    assign out_inst = empty ? '0 : r_inst_mem[r_rd_ptr];
    assign out_pc4  = empty ? '0 : r_pc4_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; reset beats flush beats push/pop.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents are left as-is on reset since pointers define validity.
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_inst_mem[r_wr_ptr] <= in_inst;
            r_pc4_mem[r_wr_ptr]  <= in_pc4;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_inst;
    logic [WIDTH-1:0] in_pc4;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_inst;
    logic [WIDTH-1:0] out_pc4;
    logic [2:0]       count;
    logic             full;
    logic             empty;

    int n_cmp = 0;
    int n_bad = 0;

    inst_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc4    (in_pc4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc4   (out_pc4),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] ii;
        logic [31:0] ip;
        logic        ordy;
        int          ecnt;
        logic [31:0] eoi;
        logic [31:0] eop;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic fl, input logic iv,
                       input logic [31:0] ii, input logic [31:0] ip, input logic ordy,
                       input int ecnt, input logic [31:0] eoi, input logic [31:0] eop);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ii = ii; v.ip = ip; v.ordy = ordy;
        v.ecnt = ecnt; v.eoi = eoi; v.eop = eop;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare every output against an expected occupancy and head entry.
    task automatic chk_state(input string tag, input int ecnt,
                             input logic [31:0] eoi, input logic [31:0] eop);
        chk({tag, ".count"},     32'(count),     32'(ecnt));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ecnt != 0));
        chk({tag, ".empty"},     32'(empty),     32'(ecnt == 0));
        chk({tag, ".full"},      32'(full),      32'(ecnt == DEPTH));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ecnt != DEPTH));
        chk({tag, ".out_inst"},  out_inst,       eoi);
        chk({tag, ".out_pc4"},   out_pc4,        eop);
    endtask

    // Drive one cycle of inputs, clock it, and sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [31:0] ii, input logic [31:0] ip, input logic ordy);
        reset = rst; flush = fl; in_valid = iv; in_inst = ii; in_pc4 = ip; out_ready = ordy;
        @(posedge clock);
        #1;
    endtask

    // Reference model: plain queue of {inst, pc4}.
    logic [63:0] mq[$];

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc4 = '0; out_ready = 1'b0;

        // ---------------- directed vector table ----------------
        // reset
        add(1,0,0,32'h0,32'h0,0,                 0, 32'h0, 32'h0);
        // fill with out_ready=0, fifth push ignored
        add(0,0,1,32'h2001_0001,32'h4,0,         1, 32'h2001_0001, 32'h4);
        add(0,0,1,32'h2002_0002,32'h8,0,         2, 32'h2001_0001, 32'h4);
        add(0,0,1,32'h2003_0003,32'hC,0,         3, 32'h2001_0001, 32'h4);
        add(0,0,1,32'h2004_0004,32'h10,0,        4, 32'h2001_0001, 32'h4);
        add(0,0,1,32'h2005_0005,32'h14,0,        4, 32'h2001_0001, 32'h4);
        // drain
        add(0,0,0,32'hDEAD_BEEF,32'h0,1,         3, 32'h2002_0002, 32'h8);
        add(0,0,0,32'h0,32'h0,1,                 2, 32'h2003_0003, 32'hC);
        add(0,0,0,32'h0,32'h0,1,                 1, 32'h2004_0004, 32'h10);
        add(0,0,0,32'h0,32'h0,1,                 0, 32'h0, 32'h0);
        // refill, then full-with-pop: pop only, push accepted next cycle
        add(0,0,1,32'h3000_0001,32'h100,0,       1, 32'h3000_0001, 32'h100);
        add(0,0,1,32'h3000_0002,32'h104,0,       2, 32'h3000_0001, 32'h100);
        add(0,0,1,32'h3000_0003,32'h108,0,       3, 32'h3000_0001, 32'h100);
        add(0,0,1,32'h3000_0004,32'h10C,0,       4, 32'h3000_0001, 32'h100);
        add(0,0,1,32'h3000_0005,32'h110,1,       3, 32'h3000_0002, 32'h104);
        add(0,0,1,32'h3000_0005,32'h110,0,       4, 32'h3000_0002, 32'h104);
        // bring to count=3, flush with push+pop
        add(0,0,0,32'h0,32'h0,1,                 3, 32'h3000_0003, 32'h108);
        add(0,1,1,32'h0BAD_0BAD,32'h99,1,        0, 32'h0, 32'h0);
        add(0,0,1,32'h0800_0010,32'h14,0,        1, 32'h0800_0010, 32'h14);
        add(0,0,1,32'h0800_0020,32'h18,1,        1, 32'h0800_0020, 32'h18);
        add(0,0,0,32'h0,32'h0,1,                 0, 32'h0, 32'h0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].fl, vq[i].iv, vq[i].ii, vq[i].ip, vq[i].ordy);
            chk_state($sformatf("vec%0d", i), vq[i].ecnt, vq[i].eoi, vq[i].eop);
        end

        // ---------------- streaming: 10 words, push+pop every cycle ----------------
        step(1,0,0,32'h0,32'h0,0);
        for (int k = 0; k < 10; k++) begin
            step(0,0,1,32'h5000_0000 + 32'(k), 32'h200 + 32'(4*k), 1);
            chk_state($sformatf("stream%0d", k), 1, 32'h5000_0000 + 32'(k), 32'h200 + 32'(4*k));
        end
        step(0,0,0,32'h0,32'h0,1);
        chk_state("stream_end", 0, 32'h0, 32'h0);

        // ---------------- reset mid-run with count=2 ----------------
        step(0,0,1,32'h6000_0001,32'h300,0);
        step(0,0,1,32'h6000_0002,32'h304,0);
        chk_state("rst_pre", 2, 32'h6000_0001, 32'h300);
        step(1,0,1,32'h6000_0003,32'h308,1);
        chk_state("rst_mid", 0, 32'h0, 32'h0);
        step(0,0,1,32'h7000_0001,32'h400,0);
        chk_state("rst_push", 1, 32'h7000_0001, 32'h400);
        step(0,0,0,32'h0,32'h0,1);
        chk_state("rst_pop", 0, 32'h0, 32'h0);

        // ---------------- randomized run vs queue model ----------------
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            logic        r_rst, r_fl, r_iv, r_or, m_push, m_pop;
            logic [31:0] r_ii, r_ip;
            logic [63:0] hd;
            r_rst = ($urandom_range(0, 49) == 0);
            r_fl  = ($urandom_range(0, 24) == 0);
            r_iv  = ($urandom_range(0, 99) < 60);
            r_or  = ($urandom_range(0, 99) < 45);
            r_ii  = $urandom;
            r_ip  = $urandom;
            m_push = r_iv && (mq.size() < DEPTH) && !r_fl;
            m_pop  = r_or && (mq.size() > 0) && !r_fl;
            if (r_rst || r_fl) begin
                mq.delete();
            end else begin
                if (m_pop)  void'(mq.pop_front());
                if (m_push) mq.push_back({r_ii, r_ip});
            end
            step(r_rst, r_fl, r_iv, r_ii, r_ip, r_or);
            hd = (mq.size() > 0) ? mq[0] : 64'h0;
            chk_state($sformatf("rnd%0d", c), mq.size(), hd[63:32], hd[31:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
